// File: rtl/flex_counter_16.sv
// Enable-gated up-counter with a programmable terminal count.
// The terminal-count flag is registered from next-state so it moves with count.
module flex_counter_16 #(
    parameter int unsigned     WIDTH        = 16,
    parameter longint unsigned ROLLOVER_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             rollover_flag
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("flex_counter_16: WIDTH must be 2..32");
    end

    if (ROLLOVER_VAL < 64'd1 ||
        ROLLOVER_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_roll
        $error("flex_counter_16: ROLLOVER_VAL out of range");
    end

    localparam logic [WIDTH-1:0] TERM = ROLLOVER_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] next_count;

    always_comb begin
        next_count = count;
        if (enable) begin
            if (count == TERM) begin
                next_count = '0;
            end else begin
                next_count = count + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count         <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count         <= next_count;
            rollover_flag <= (next_count == TERM);
        end
    end

endmodule

// File: tb/tb_flex_counter_16.sv
// Bench for flex_counter_16: default 16-bit instance plus a
// 4-bit instance wrapping at 5, checked against an edge-count model.
module tb_flex_counter_16;

    logic        clk;
    logic        nrst;
    logic        en_a;
    logic        en_b;
    logic [15:0] cnt_a;
    logic        flg_a;
    logic [3:0]  cnt_b;
    logic        flg_b;

    int errors = 0;
    int checks = 0;

    // model: number of enabled edges since last reset
    longint na = 0;
    longint nb = 0;

    flex_counter_16 dut_a (
        .clk(clk),
        .nrst(nrst),
        .enable(en_a),
        .count(cnt_a),
        .rollover_flag(flg_a)
    );

    flex_counter_16 #(
        .WIDTH(4),
        .ROLLOVER_VAL(5)
    ) dut_b (
        .clk(clk),
        .nrst(nrst),
        .enable(en_b),
        .count(cnt_b),
        .rollover_flag(flg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit en;
        int cnt;
        bit flg;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        longint ea;
        longint eb;
        ea = na % 65536;
        eb = nb % 6;
        check({name, " cnt_a"}, longint'(cnt_a), ea);
        check({name, " flg_a"}, longint'(flg_a), longint'(ea == 65535));
        check({name, " cnt_b"}, longint'(cnt_b), eb);
        check({name, " flg_b"}, longint'(flg_b), longint'(eb == 5));
    endtask

    task automatic tick(input bit ea, input bit eb, input bit do_chk,
                        input string name);
        en_a = ea;
        en_b = eb;
        @(posedge clk);
        if (nrst) begin
            if (ea) na++;
            if (eb) nb++;
        end
        #1;
        if (do_chk) check_model(name);
    endtask

    task automatic pulse_reset(input string name);
        nrst = 1'b0;
        na = 0;
        nb = 0;
        #1;
        check({name, " async cnt_a"}, longint'(cnt_a), 0);
        check({name, " async flg_a"}, longint'(flg_a), 0);
        check({name, " async cnt_b"}, longint'(cnt_b), 0);
        check({name, " async flg_b"}, longint'(flg_b), 0);
        #1;
        nrst = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1, 1, 0};
        tbl[1]  = '{1, 2, 0};
        tbl[2]  = '{1, 3, 0};
        tbl[3]  = '{1, 4, 0};
        tbl[4]  = '{1, 5, 1};
        tbl[5]  = '{0, 5, 1};
        tbl[6]  = '{0, 5, 1};
        tbl[7]  = '{1, 0, 0};
        tbl[8]  = '{1, 1, 0};
        tbl[9]  = '{0, 1, 0};
        tbl[10] = '{1, 2, 0};
        tbl[11] = '{1, 3, 0};

        nrst = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset asserted between edges must clear at once
        pulse_reset("power_on");
        nrst = 1'b0;
        en_a = 1'b1;
        en_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("in_reset cnt_a", longint'(cnt_a), 0);
        check("in_reset cnt_b", longint'(cnt_b), 0);
        nrst = 1'b1;

        for (int i = 0; i < 32; i++) begin
            tick(1'b1, 1'b0, 1'b1, "count");
            check("count step", longint'(cnt_a), longint'(i + 1));
        end
        for (int i = 0; i < 32; i++) begin
            tick(1'b0, 1'b0, 1'b1, "hold");
        end
        check("hold value", longint'(cnt_a), 32);

        // toggling between edges: only the edge value counts
        en_a = 1'b1;
        #2;
        en_a = 1'b0;
        tick(1'b0, 1'b0, 1'b1, "toggle");
        check("toggle value", longint'(cnt_a), 32);

        for (int i = 0; i < 12; i++) begin
            tick(1'b0, tbl[i].en, 1'b1, "table");
            check("table cnt_b", longint'(cnt_b), longint'(tbl[i].cnt));
            check("table flg_b", longint'(flg_b), longint'(tbl[i].flg));
        end

        // mid-count reset at 20, then resume from 0
        pulse_reset("pre_mid");
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0, "");
        check("mid pre cnt_a", longint'(cnt_a), 20);
        en_a = 1'b1;
        pulse_reset("mid");
        tick(1'b1, 1'b1, 1'b1, "mid after");
        check("mid resume", longint'(cnt_a), 1);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) pulse_reset("rand");
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b1, "rand");
        end

        // default terminal count FFFF -> 0000
        pulse_reset("wrap");
        for (int i = 0; i < 65534; i++) tick(1'b1, 1'b0, 1'b0, "");
        check("wrap pre cnt", longint'(cnt_a), 65534);
        check("wrap pre flg", longint'(flg_a), 0);
        tick(1'b1, 1'b0, 1'b1, "wrap ffff");
        check("wrap ffff cnt", longint'(cnt_a), 65535);
        check("wrap ffff flg", longint'(flg_a), 1);
        tick(1'b0, 1'b0, 1'b1, "wrap hold");
        check("wrap hold flg", longint'(flg_a), 1);
        tick(1'b1, 1'b0, 1'b1, "wrap zero");
        check("wrap zero cnt", longint'(cnt_a), 0);
        check("wrap zero flg", longint'(flg_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flex_counter_16.md
# flex_counter_16

Parameterizable up-counter with an enable and a programmable rollover point, used as the cycle/event counter primitive inside functional units such as the branch unit. It advances by one on each clock edge where `enable` is high, holds otherwise, and wraps to zero after reaching its rollover value. A registered `rollover_flag` marks the terminal count for downstream control.

## Interface
Parameters:
- `WIDTH`, 16, counter width in bits; legal range 2..32.
- `ROLLOVER_VAL`, 2^WIDTH-1 (all ones), terminal count; legal range 1..2^WIDTH-1; elaboration error outside it.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  system clock, rising-edge active.
- `nrst`  input  1  asynchronous active-low reset.
- `enable`  input  1  count-enable, sampled on rising `clk`.
- `count`  output  WIDTH  current count, unsigned; index 0 is the LSB (numeric weight 2^0).
- `rollover_flag`  output  1  high exactly while `count == ROLLOVER_VAL`.

## Operation
- State: registered `count` and registered `rollover_flag`; no other state.
- Reset (`nrst`=0): `count` = 0, `rollover_flag` = 0, immediately and independent of `clk`; both hold while `nrst` is low regardless of `enable`.
- `enable`=1 at a rising edge:
  - `count` < `ROLLOVER_VAL`: next `count` = `count`+1.
  - `count` == `ROLLOVER_VAL`: next `count` = 0 (wrap).
- `enable`=0 at a rising edge: `count` and `rollover_flag` hold.
- `rollover_flag` next value = (next `count` == `ROLLOVER_VAL`); computed from next-state so flag and count change on the same edge, glitch-free from a register.
- Arithmetic: unsigned, modulo never exceeded; `count` never takes a value above `ROLLOVER_VAL`. With default `ROLLOVER_VAL` the wrap is FFFF→0000 for WIDTH=16.
- Reset mid-count overrides any enable; counting resumes from 0 afterwards.

## Timing
- Latency: one cycle; `count` reflects an `enable` sampled at edge N immediately after edge N.
- N consecutive enabled edges from 0 yield `count` = N (mod `ROLLOVER_VAL`+1).
- After `nrst` deasserts, the first increment occurs at the first rising edge with `nrst`=1 and `enable`=1; deassertion is assumed synchronized externally (no recovery logic inside).
- `enable` toggling between edges has no effect; only the value at the rising edge matters.
- `rollover_flag` asserts on the edge `count` becomes `ROLLOVER_VAL` and deasserts on the edge it wraps to 0; it stays high for as long as `enable` stays low at the terminal count.

## Test plan
- Power-on: `nrst`=1, `enable`=0 for 2 cycles, then `nrst`=0 for 2 cycles -> `count`=0, `rollover_flag`=0 asynchronously, before any clock edge.
- Count: after reset release, `enable`=1 for 32 cycles -> `count` steps 1,2,…,32, one per edge; `rollover_flag`=0 throughout (default params).
- Hold: then `enable`=0 for 32 cycles -> `count` stays 32; `rollover_flag` stays 0.
- Wrap (ROLLOVER_VAL=5): enable continuously -> 0,1,2,3,4,5,0,1…; `rollover_flag`=1 only while `count`=5; with `enable` dropped at 5, `count`=5 and flag=1 held.
- Default wrap: preload by counting to 16'hFFFE, enable 2 edges -> FFFF (flag=1) then 0000 (flag=0).
- Mid-operation reset: at `count`=20 with `enable`=1, pulse `nrst` low between edges -> `count`=0 immediately; after release, next enabled edge gives 1.
